link_slave_rx: RTL

//  Receive-side responder for the 4-phase req/ack byte link. Captures one byte per

---
 rtl/link_slave_rx.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/link_slave_rx.sv
// Receive side of the 4-phase req/ack byte link: captures one byte per handshake and assembles bursts.
// Latency: ack rises ACK_DELAY edges after req is first sampled high (same edge when ACK_DELAY=0).
// Backpressure: ack is held until ACK_HOLD cycles have elapsed and req has dropped; the master waits on ack.
//
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   req, data_in request and byte from the link master (data_in sampled once per handshake)
//   ack          acknowledge back to the master
//   last_byte    most recently accepted byte; byte_valid pulses when it updates
//   byte_idx     slot that the next accepted byte will fill
//   burst_data   assembled burst, slot i at [i*DATA_W +: DATA_W]; burst_done pulses on the last slot
//   burst_cnt    completed bursts (wraps); proto_err sticky flag for req dropping before ack
module link_slave_rx #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int ACK_DELAY = 2,
    parameter int ACK_HOLD  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req,
    input  logic [DATA_W-1:0]             data_in,
    output logic                          ack,
    output logic [DATA_W-1:0]             last_byte,
    output logic                          byte_valid,
    output logic [$clog2(BURST_LEN)-1:0]  byte_idx,
    output logic [BURST_LEN*DATA_W-1:0]   burst_data,
    output logic                          burst_done,
    output logic [7:0]                    burst_cnt,
    output logic                          proto_err
);

    localparam int IDX_W = $clog2(BURST_LEN);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_DLY = 2'd1;
    localparam logic [1:0] S_ACK_HI   = 2'd2;

    // dly_cnt is cleared on the capture edge, so ack must rise when it reaches ACK_DELAY-1.
    localparam logic [3:0]       DLY_LAST = (ACK_DELAY == 0) ? 4'd0 : 4'(ACK_DELAY - 1);
    localparam logic [3:0]       HOLD_MIN = 4'(ACK_HOLD);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BURST_LEN - 1);

    logic [1:0]                  state_q, state_d;
    logic [DATA_W-1:0]           cap_q, cap_d;
    logic [3:0]                  dly_cnt_q, dly_cnt_d;
    logic [3:0]                  hold_cnt_q, hold_cnt_d;
    logic                        ack_q, ack_d;
    logic                        proto_err_q, proto_err_d;
    logic [DATA_W-1:0]           last_byte_q, last_byte_d;
    logic                        byte_valid_q, byte_valid_d;
    logic                        burst_done_q, burst_done_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BURST_LEN*DATA_W-1:0] burst_q, burst_d;
    logic [7:0]                  burst_cnt_q, burst_cnt_d;

    // Ack-rise event and the byte it delivers (data_in directly when there is no delay).
    logic                        rise;
    logic [DATA_W-1:0]           rise_byte;

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        dly_cnt_d   = dly_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        ack_d       = ack_q;
        proto_err_d = proto_err_q;
        rise        = 1'b0;
        rise_byte   = cap_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cap_d = data_in;
                    if (ACK_DELAY == 0) begin
                        rise      = 1'b1;
                        rise_byte = data_in;
                    end else begin
                        dly_cnt_d = 4'd0;
                        state_d   = S_WAIT_DLY;
                    end
                end
            end
            S_WAIT_DLY: begin
                if (!req) begin
                    // Master abandoned the handshake: byte dropped, link stays usable.
                    proto_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (dly_cnt_q == DLY_LAST) begin
                    rise = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 4'd1;
                end
            end
            S_ACK_HI: begin
                if ((hold_cnt_q >= HOLD_MIN) && !req) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (hold_cnt_q != 4'hF) begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // hold_cnt starts at 1: by the next edge ack will have been high for one cycle.
        if (rise) begin
            ack_d      = 1'b1;
            hold_cnt_d = 4'd1;
            state_d    = S_ACK_HI;
        end
    end

    always_comb begin
        last_byte_d  = last_byte_q;
        byte_valid_d = rise;
        burst_done_d = 1'b0;
        idx_d        = idx_q;
        burst_d      = burst_q;
        burst_cnt_d  = burst_cnt_q;

        if (rise) begin
            last_byte_d = rise_byte;
            for (int i = 0; i < BURST_LEN; i++) begin
                if (IDX_W'(i) == idx_q) begin
                    burst_d[i*DATA_W +: DATA_W] = rise_byte;
                end
            end
            if (idx_q == IDX_LAST) begin
                idx_d        = '0;
                burst_done_d = 1'b1;
                burst_cnt_d  = burst_cnt_q + 8'd1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cap_q        <= '0;
            dly_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            ack_q        <= 1'b0;
            proto_err_q  <= 1'b0;
            last_byte_q  <= '0;
            byte_valid_q <= 1'b0;
            burst_done_q <= 1'b0;
            idx_q        <= '0;
            burst_q      <= '0;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cap_q        <= cap_d;
            dly_cnt_q    <= dly_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            ack_q        <= ack_d;
            proto_err_q  <= proto_err_d;
            last_byte_q  <= last_byte_d;
            byte_valid_q <= byte_valid_d;
            burst_done_q <= burst_done_d;
            idx_q        <= idx_d;
            burst_q      <= burst_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    assign ack        = ack_q;
    assign last_byte  = last_byte_q;
    assign byte_valid = byte_valid_q;
    assign byte_idx   = idx_q;
    assign burst_data = burst_q;
    assign burst_done = burst_done_q;
    assign burst_cnt  = burst_cnt_q;
    assign proto_err  = proto_err_q;

endmodule
